// File: rtl/mdio_master.sv
// mdio_master: Clause 22 MDIO master shared by a host register port and an
// optional autonomous BMSR link poller (build with MDIO_LINK_POLL_EN).
// Ports: sysclk, reset_n (async, active low); mdc, mdio_o, mdio_t, mdio_i
// pins; host_req/host_rd/host_phy/host_reg/host_wdata request in,
// host_ack/host_rdata completion out; busy; link_on (BMSR bit 2).
module mdio_master #(
    parameter int          CLK_DIV     = 20,
    parameter logic [23:0] POLL_PERIOD = 24'd2000000,
    parameter logic [4:0]  POLL_PHY    = 5'd1
) (
    input  logic        sysclk,
    input  logic        reset_n,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i,
    input  logic        host_req,
    input  logic        host_rd,
    input  logic [4:0]  host_phy,
    input  logic [4:0]  host_reg,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    output logic        busy,
    output logic        link_on
);

    typedef enum logic [1:0] {IDLE, PRE, FRAME, DONE} state_t;

    localparam int DW = $clog2(2 * CLK_DIV);

    state_t        state, state_d;
    logic [DW-1:0] div_cnt;
    logic [4:0]    bit_cnt;
    logic [31:0]   tx_sr;
    logic [15:0]   rx_sr;
    logic          cur_rd;
    logic          cur_poll;
    logic          poll_pend;
    logic          take_host;
    logic          take_poll;
    logic          mdc_rise;
    logic          mdc_fall;
    logic          bit_last;

    assign mdc_rise = (div_cnt == DW'(CLK_DIV - 1));
    assign mdc_fall = (div_cnt == DW'(2 * CLK_DIV - 1));
    assign bit_last = (bit_cnt == 5'd31);
    assign busy     = (state != IDLE);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Host wins arbitration, but not in the cycle its previous ack is
    // still visible; a poll may start in that cycle.
    always_comb begin
        state_d   = state;
        take_host = 1'b0;
        take_poll = 1'b0;
        unique case (state)
            IDLE: begin
                if (host_req && !host_ack) begin
                    take_host = 1'b1;
                    state_d   = PRE;
                end else if (poll_pend) begin
                    take_poll = 1'b1;
                    state_d   = PRE;
                end
            end
            PRE:     if (mdc_fall && bit_last) state_d = FRAME;
            FRAME:   if (mdc_fall && bit_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            cur_rd     <= 1'b0;
            cur_poll   <= 1'b0;
            mdc        <= 1'b0;
            mdio_o     <= 1'b1;
            mdio_t     <= 1'b1;
            host_ack   <= 1'b0;
            host_rdata <= '0;
        end else begin
            host_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take_host || take_poll) begin
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        mdc      <= 1'b0;
                        mdio_o   <= 1'b1;
                        mdio_t   <= 1'b0;
                        cur_poll <= take_poll;
                        cur_rd   <= take_poll | host_rd;
                        if (take_poll)
                            tx_sr <= {2'b01, 2'b10, POLL_PHY, 5'd1,
                                      2'b10, 16'h0000};
                        else if (host_rd)
                            tx_sr <= {2'b01, 2'b10, host_phy, host_reg,
                                      2'b10, 16'h0000};
                        else
                            tx_sr <= {2'b01, 2'b01, host_phy, host_reg,
                                      2'b10, host_wdata};
                    end
                end
                PRE, FRAME: begin
                    div_cnt <= mdc_fall ? '0 : div_cnt + DW'(1);
                    if (mdc_rise) mdc <= 1'b1;
                    // bit_cnt[4] marks frame bits 16..31, the data field
                    if (state == FRAME && mdc_rise && bit_cnt[4])
                        rx_sr <= {rx_sr[14:0], mdio_i};
                    if (mdc_fall) begin
                        mdc     <= 1'b0;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (state == PRE) begin
                            if (bit_last) begin
                                mdio_o <= tx_sr[31];
                                tx_sr  <= {tx_sr[30:0], 1'b0};
                            end
                        end else if (bit_last) begin
                            mdio_o <= 1'b1;
                            mdio_t <= 1'b1;
                        end else begin
                            mdio_o <= tx_sr[31];
                            tx_sr  <= {tx_sr[30:0], 1'b0};
                            // release the line for TA on reads
                            if (cur_rd && bit_cnt == 5'd13)
                                mdio_t <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!cur_poll) begin
                        host_ack <= 1'b1;
                        if (cur_rd) host_rdata <= rx_sr;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MDIO_LINK_POLL_EN
    logic [23:0] poll_cnt;
    logic        link_q;

    // An expiry on the same edge as a poll completing re-arms the poll.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
            link_q    <= 1'b0;
        end else begin
            if (state == DONE && cur_poll) begin
                poll_pend <= 1'b0;
                link_q    <= rx_sr[2];
            end
            if (poll_cnt == POLL_PERIOD - 24'd1) begin
                poll_cnt  <= '0;
                poll_pend <= 1'b1;
            end else begin
                poll_cnt <= poll_cnt + 24'd1;
            end
        end
    end

    assign link_on = link_q;
`else
    assign poll_pend = 1'b0 & (POLL_PERIOD == 24'd0);
    assign link_on   = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed bench for mdio_master with a serial PHY model,
// a transaction-level reference model and a per-cycle output compare.
module tb_mdio_master;

    localparam int          CD   = 2;
    localparam logic [23:0] PP   = 24'd400;
    localparam int          TLEN = 128 * CD;

    logic        sysclk = 1'b0;
    logic        reset_n;
    logic        mdc, mdio_o, mdio_t, mdio_i;
    logic        host_req, host_rd;
    logic [4:0]  host_phy, host_reg;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        busy, link_on;

    mdio_master #(
        .CLK_DIV(CD), .POLL_PERIOD(PP), .POLL_PHY(5'd1)
    ) dut (
        .sysclk(sysclk), .reset_n(reset_n),
        .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i),
        .host_req(host_req), .host_rd(host_rd),
        .host_phy(host_phy), .host_reg(host_reg),
        .host_wdata(host_wdata), .host_ack(host_ack),
        .host_rdata(host_rdata), .busy(busy), .link_on(link_on)
    );

    always #5 sysclk = ~sysclk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge sysclk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // ---------------- PHY model (decodes the serial frame) ----------------
    logic [15:0] phy_regs [32];
    logic        phy_drv = 1'b0;
    logic        phy_val = 1'b1;
    logic [63:0] mon = '1;
    logic [12:0] hdr = '0;
    logic [17:0] wsr = '0;
    logic [15:0] rd_q = '0;
    int          p_st = 0, p_cnt = 0, p_ones = 0;

    assign mdio_i = phy_drv ? phy_val : (mdio_t ? 1'b1 : mdio_o);

    always @(posedge mdc or negedge mdc or negedge reset_n) begin
        if (!reset_n) begin
            p_st = 0; p_cnt = 0; p_ones = 0; phy_drv = 1'b0;
        end else if (mdc) begin
            mon = {mon[62:0], mdio_i};
            case (p_st)
                0: begin
                    if (mdio_i) p_ones++;
                    else begin
                        if (p_ones >= 32) begin p_st = 1; p_cnt = 0; end
                        p_ones = 0;
                    end
                end
                1: begin
                    hdr = {hdr[11:0], mdio_i};
                    p_cnt++;
                    if (p_cnt == 13) begin
                        p_cnt = 0;
                        if (hdr[12] && hdr[9:5] == 5'd1 && hdr[11:10] == 2'b10) begin
                            p_st = 3;
                            rd_q = phy_regs[hdr[4:0]];
                        end else if (hdr[12] && hdr[9:5] == 5'd1 && hdr[11:10] == 2'b01)
                            p_st = 2;
                        else
                            p_st = 0;
                    end
                end
                2: begin
                    wsr = {wsr[16:0], mdio_i};
                    p_cnt++;
                    if (p_cnt == 18) begin
                        phy_regs[hdr[4:0]] = wsr[15:0];
                        p_st = 0;
                    end
                end
                3: begin
                    p_cnt++;
                    if (p_cnt == 18) p_st = 0;
                end
                default: p_st = 0;
            endcase
        end else begin
            phy_drv = (p_st == 3 && p_cnt >= 1);
            if (p_st == 3 && p_cnt == 1) phy_val = 1'b0;
            else if (p_st == 3 && p_cnt >= 2) phy_val = rd_q[17 - p_cnt];
            else phy_val = 1'b1;
        end
    end

    // ---------------- transaction-level reference model ----------------
    int          m_k = -1;
    bit          m_poll = 0, m_rd = 0;
    logic [31:0] m_frame = '0;
    logic [15:0] m_data = '0;
    logic        m_ack = 0;
    logic [15:0] m_rdata = '0;
    logic        m_link = 0;
    int          m_tcnt = 0;
    bit          m_pend = 0;
    int          m_polls = 0;

    always @(posedge sysclk or negedge reset_n) begin
        bit was_ack, old_pend;
        if (!reset_n) begin
            m_k = -1; m_ack = 0; m_rdata = '0; m_link = 0;
            m_tcnt = 0; m_pend = 0;
        end else begin
            was_ack  = m_ack;
            old_pend = m_pend;
            m_ack    = 0;
            if (m_k < 0) begin
                if (host_req && !was_ack) begin
                    m_k = 0; m_poll = 0; m_rd = host_rd;
                    m_frame = {2'b01, host_rd ? 2'b10 : 2'b01, host_phy,
                               host_reg, 2'b10,
                               host_rd ? 16'h0 : host_wdata};
                    m_data = (host_phy == 5'd1) ? phy_regs[host_reg] : 16'hffff;
                end else if (old_pend) begin
                    m_k = 0; m_poll = 1; m_rd = 1;
                    m_frame = {2'b01, 2'b10, 5'd1, 5'd1, 2'b10, 16'h0};
                    m_data = phy_regs[1];
                end
            end else begin
                m_k++;
                if (m_k == TLEN + 1) begin
                    if (m_poll) begin
                        m_link = m_data[2]; m_pend = 0; m_polls++;
                    end else begin
                        m_ack = 1;
                        if (m_rd) m_rdata = m_data;
                    end
                    m_k = -1;
                end
            end
`ifdef MDIO_LINK_POLL_EN
            if (m_tcnt == int'(PP) - 1) begin m_tcnt = 0; m_pend = 1; end
            else m_tcnt++;
`endif
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge sysclk) begin
        logic e_mdc, e_busy, e_io, e_o, e_t;
        int nb, fb;
        if (reset_n) begin
            e_mdc = 0; e_busy = 0; e_io = 0; e_o = 1; e_t = 0;
            if (m_k >= 0) begin
                e_busy = 1;
                if (m_k < TLEN) begin
                    nb    = m_k / (2 * CD);
                    e_mdc = ((m_k % (2 * CD)) >= CD);
                    e_io  = 1;
                    if (nb >= 32) begin
                        fb  = nb - 32;
                        e_o = m_frame[31 - fb];
                        if (m_rd && fb >= 14) e_t = 1;
                    end
                end
            end
            chk("cyc_mdc", mdc, e_mdc);
            chk("cyc_busy", busy, e_busy);
            chk("cyc_host_ack", host_ack, m_ack);
            chk("cyc_host_rdata", host_rdata, m_rdata);
            chk("cyc_link_on", link_on, m_link);
            if (e_io) begin
                chk("cyc_mdio_t", mdio_t, e_t);
                if (!e_t) chk("cyc_mdio_o", mdio_o, e_o);
            end
        end
    end

    // ---------------- host requester ----------------
    task automatic host_op(input bit rd, input logic [4:0] reg_a,
                           input logic [15:0] wd, output int lat,
                           output int t_hi, output int total);
        int  rise_c, c_in;
        bit  prev_busy, done;
        host_req = 1; host_rd = rd; host_phy = 5'd1;
        host_reg = reg_a; host_wdata = wd;
        c_in = cyc; rise_c = -1; lat = -1; total = -1; t_hi = 0;
        prev_busy = busy; done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge sysclk);
            if (busy && !prev_busy) begin rise_c = cyc; t_hi = 0; end
            if (busy && mdc && mdio_t) t_hi++;
            prev_busy = busy;
            if (host_ack) begin
                lat = cyc - rise_c; total = cyc - c_in; done = 1;
            end
        end
        host_req = 0;
        chk("host_ack_seen", done, 1);
    endtask

    task automatic wait_poll(output bit ok);
        int p0;
        p0 = m_polls; ok = 0;
        for (int i = 0; i < 3 * int'(PP) && !ok; i++) begin
            @(negedge sysclk);
            if (m_polls != p0) ok = 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, thi, tot, cnt;
        bit ok;
        reset_n = 0; host_req = 0; host_rd = 0;
        host_phy = 0; host_reg = 0; host_wdata = 0;
        for (int i = 0; i < 32; i++) phy_regs[i] = 16'h0;
        phy_regs[1] = 16'h79ad;
        phy_regs[2] = 16'h7e19;
        repeat (3) @(negedge sysclk);
        chk("rst_mdc", mdc, 0);
        chk("rst_mdio_o", mdio_o, 1);
        chk("rst_mdio_t", mdio_t, 1);
        chk("rst_host_ack", host_ack, 0);
        chk("rst_host_rdata", host_rdata, 16'h0);
        chk("rst_busy", busy, 0);
        chk("rst_link_on", link_on, 0);
        reset_n = 1;
        repeat (2) @(negedge sysclk);

        host_op(0, 5'd0, 16'h1040, lat, thi, tot);
        chk("wr_latency", lat, 257);
        chk("wr_preamble", mon[63:32], 32'hffffffff);
        chk("wr_frame", mon[31:0], 32'h50821040);
        chk("wr_mdio_t_high", thi, 0);
        chk("wr_phy_reg0", phy_regs[0], 16'h1040);
        @(negedge sysclk);

        host_op(1, 5'd2, 16'h0, lat, thi, tot);
        chk("rd_latency", lat, 257);
        chk("rd_mdio_t_high", thi, 36);
        chk("rd_data", host_rdata, 16'h7e19);
        @(negedge sysclk);

        host_req = 1; host_rd = 1; host_phy = 5'd1; host_reg = 5'd2;
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge sysclk);
            if (m_k == 0 && !m_poll) ok = 1;
        end
        chk("mid_accept", ok, 1);
        repeat (40 * 2 * CD + 1) @(negedge sysclk);
        reset_n = 0;
        #1;
        chk("mid_rst_mdc", mdc, 0);
        chk("mid_rst_mdio_o", mdio_o, 1);
        chk("mid_rst_mdio_t", mdio_t, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_host_ack", host_ack, 0);
        chk("mid_rst_host_rdata", host_rdata, 16'h0);
        chk("mid_rst_link_on", link_on, 0);
        host_req = 0;
        cnt = 0;
        repeat (4) begin
            @(negedge sysclk);
            if (host_ack) cnt++;
        end
        chk("mid_rst_no_ack", cnt, 0);
        reset_n = 1;
        repeat (2) @(negedge sysclk);
        host_op(1, 5'd2, 16'h0, lat, thi, tot);
        chk("post_rst_latency", lat, 257);
        chk("post_rst_data", host_rdata, 16'h7e19);

`ifdef MDIO_LINK_POLL_EN
        wait_poll(ok);
        chk("poll_up_seen", ok, 1);
        chk("poll_link_up", link_on, 1);
        phy_regs[1] = 16'h79a9;
        wait_poll(ok);
        chk("poll_down_seen", ok, 1);
        chk("poll_link_down", link_on, 0);
        chk("poll_rdata_kept", host_rdata, 16'h7e19);

        ok = 0;
        for (int i = 0; i < 3 * int'(PP) && !ok; i++) begin
            @(negedge sysclk);
            if (m_k < 0 && !m_pend && !m_ack && m_tcnt == int'(PP) - 1)
                ok = 1;
        end
        chk("coll_align", ok, 1);
        phy_regs[1] = 16'h79ad;
        host_op(1, 5'd2, 16'h0, lat, thi, tot);
        chk("coll_host_latency", lat, 257);
        chk("coll_host_first", tot, 258);
        chk("coll_busy_at_ack", busy, 0);
        @(negedge sysclk);
        chk("coll_poll_start", busy, 1);
        wait_poll(ok);
        chk("coll_poll_seen", ok, 1);
        chk("coll_rdata_kept", host_rdata, 16'h7e19);
        chk("coll_link_up", link_on, 1);
`else
        cnt = 0;
        for (int i = 0; i < 10 * int'(PP); i++) begin
            @(negedge sysclk);
            if (mdc || busy || link_on) cnt++;
        end
        chk("idle_no_activity", cnt, 0);
        chk("idle_link_off", link_on, 0);
`endif

        repeat (4) @(negedge sysclk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdio_master.md
# mdio_master

MDIO management master that runs IEEE 802.3 Clause 22 read and write transactions to an Ethernet PHY on the board. It shares the one MDIO bus between two requesters: host register accesses from the Ethernet control path, and an optional autonomous poller. The poller reads BMSR periodically and publishes link status. The block sits between the Ethernet control/register logic and the MDIO pins (or a virtual PHY), and it generates MDC from sysclk.

## Interface
Parameters:
- CLK_DIV, 20: sysclk cycles per MDC half-period; must be ≥2.
- POLL_PERIOD, 24'd2000000: sysclk cycles between autonomous BMSR polls.
- POLL_PHY, 5'd1: PHY address used by the poller.

Ports:
- sysclk  in  1  system clock; all logic runs on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mdc  out  1  MDIO clock.
- mdio_o  out  1  serial data driven by the master.
- mdio_t  out  1  tristate control; 1 = released, with the PHY or pull-up driving the line.
- mdio_i  in  1  serial data from the PHY.
- host_req  in  1  level request; held high until host_ack.
- host_rd  in  1  1 = read, 0 = write; sampled at acceptance.
- host_phy  in  5  PHY address.
- host_reg  in  5  register address.
- host_wdata  in  16  write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  16  read data; valid from host_ack onward, held until the next host read.
- busy  out  1  a transaction is in progress.
- link_on  out  1  BMSR bit 2 from the last poll.

## Operation
- States:
  - IDLE
  - PRE: 32 MDC periods with mdio_o=1.
  - FRAME: 32 MDC periods.
  - DONE: 1 sysclk cycle.
- Frame word, MSB first: {2'b01, op, phy[4:0], reg[4:0], ta[1:0], data[15:0]}.
  - op is 2'b10 for a read, 2'b01 for a write.
  - For a write, ta=2'b10 and data=host_wdata.
- Bus direction:
  - mdio_t=0 throughout PRE and FRAME for a write.
  - For a read, mdio_t=1 from frame bit 14 (first TA bit) to the end of FRAME.
- Read capture: data bits are captured MSB first from frame bits 16..31 into a shift register. On a host read, the result is copied to host_rdata in DONE.
- Arbitration, evaluated only in IDLE:
  - host_req wins over a pending poll.
  - A pending poll is served when host_req=0.
  - A request is never preempted mid-transaction.
- IDLE does not accept host_req during the cycle host_ack=1. The requester must drop host_req on the edge at which it samples host_ack=1.
- Poll timer:
  - Free-running count of POLL_PERIOD sysclk cycles.
  - On expiry it sets poll_pend and restarts; a second expiry while pending is absorbed.
  - A poll reads reg 1 of POLL_PHY. In DONE, link_on <= rdata[2] and poll_pend is cleared.
  - A poll never asserts host_ack and never changes host_rdata.
- Reset values: mdc=0, mdio_o=1, mdio_t=1, host_ack=0, host_rdata=0, busy=0, link_on=0. Poll timer and poll_pend are cleared.
- Reset asserted mid-transaction aborts immediately to the reset values. No host_ack is issued; the requester re-issues after release.

## Timing
- MDC period is 2*CLK_DIV sysclk cycles. mdc is 0 in IDLE and DONE.
- Each MDC period is CLK_DIV cycles low, then CLK_DIV cycles high.
- mdio_o and mdio_t change only on the sysclk edge that drives mdc 1→0, or at entry to PRE.
- mdio_i is sampled on the sysclk edge that drives mdc 0→1.
- Acceptance edge (IDLE with a request): busy=1, operands latched.
- Latency from acceptance edge to host_ack=1: 64*2*CLK_DIV + 1 sysclk cycles. busy falls at the same edge host_ack rises.
- Back-to-back transactions: the minimum gap between host_ack and the next acceptance is 1 cycle.

## Configuration
- MDIO_LINK_POLL_EN defined: poll timer, poll_pend and link_on update logic are compiled in.
- MDIO_LINK_POLL_EN undefined: no poller is built, link_on is tied 0, and the bus is used only by host requests.

## Test plan
- Write, CLK_DIV=2, phy=1, reg=0, wdata=16'h1040:
  - mdio_o carries 32 ones, then 01 01 00001 00000 10 0001000001000000.
  - mdio_t=0 throughout.
  - host_ack arrives 257 cycles after acceptance.
- Read, phy=1, reg=2, PHY model returns 16'h7e19:
  - mdio_t=1 exactly for frame bits 14–31.
  - host_rdata=16'h7e19 at host_ack.
- host_req and poll expiry on the same cycle:
  - Host transaction completes first.
  - Poll starts 1 cycle after host_ack.
  - host_rdata is unchanged by the poll.
- Polling (macro on):
  - Model BMSR=16'h79ad gives link_on=1 after the poll.
  - Then BMSR=16'h79a9 gives link_on=0.
- reset_n low at frame bit 40:
  - Outputs return to reset values in the same cycle; no host_ack.
  - A new read after release completes correctly.
- Macro off: with 10*POLL_PERIOD cycles and no host_req, mdc stays 0, busy stays 0 and link_on stays 0.
